// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory responder: access sizes, MMIO
// addresses, halt FSM states and the byte-lane enable helper.
package riscv_pkg;
  localparam int XLEN      = 32;
  localparam int NUM_LANES = XLEN / 8;

  localparam logic [2:0] ACC_BYTE = 3'b001;
  localparam logic [2:0] ACC_HALF = 3'b010;
  localparam logic [2:0] ACC_WORD = 3'b100;

  localparam logic [XLEN-1:0] CONS_ADR   = 32'h1000_0000;
  localparam logic [XLEN-1:0] TOHOST_ADR = 32'h1000_0004;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } halt_st_e;

  // Byte lanes touched by an access of the given size at byte offset off.
  // An unknown size touches nothing.
  function automatic logic [NUM_LANES-1:0] lane_en(input logic [2:0] size,
                                                   input logic [1:0] off);
    logic [NUM_LANES-1:0] en;
    en = '0;
    case (size)
      ACC_BYTE: en = 4'b0001 << off;
      ACC_HALF: en = off[1] ? 4'b1100 : 4'b0011;
      ACC_WORD: en = 4'b1111;
      default:  en = '0;
    endcase
    return en;
  endfunction
endpackage

// File: rtl/dmem_resp_if.sv
// Core data-access bus between the core (master) and dmem_resp (slave).
//   adr_v_i       access valid this cycle
//   adr_i         byte address
//   is_store_i    1 = store, 0 = load
//   store_data_i  right-justified store data
//   access_size_i ACC_BYTE / ACC_HALF / ACC_WORD
//   load_data_o   combinational right-justified load data
interface dmem_resp_if;
  import riscv_pkg::*;

  logic            adr_v_i;
  logic [XLEN-1:0] adr_i;
  logic            is_store_i;
  logic [XLEN-1:0] store_data_i;
  logic [2:0]      access_size_i;
  logic [XLEN-1:0] load_data_o;

  modport slave (
    input  adr_v_i, adr_i, is_store_i, store_data_i, access_size_i,
    output load_data_o
  );

  modport master (
    output adr_v_i, adr_i, is_store_i, store_data_i, access_size_i,
    input  load_data_o
  );
endinterface

// File: rtl/cons_fifo.sv
// Console byte FIFO. Pointers carry one extra bit so full and empty are
// told apart when the index bits match.
//   push_i/din_i  write request; accepted when not full, or when full and
//                 a pop happens in the same cycle
//   pop_i         pop request; ignored when empty
//   dout_o        head entry, empty_o / full_o status
module cons_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             push_ok, pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign dout_o  = mem_q[rd_q[PW-1:0]];

  assign pop_ok  = pop_i & ~empty_o;
  // When full, the slot being written is the one popped this cycle.
  assign push_ok = push_i & (~full_o | pop_ok);

  assign wr_d = wr_q + (PW+1)'(push_ok);
  assign rd_d = rd_q + (PW+1)'(pop_ok);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[PW-1:0]] <= din_i;
  end
endmodule

// File: rtl/dmem_resp.sv
// Test-bench data memory: word RAM with asynchronous reads, a console
// FIFO at CONS_ADR, and a TOHOST register driving a RUN/DONE halt FSM.
//   clk, reset_n   clock, async active-low reset
//   bus            core access bus (slave side)
//   cons_rd_i      drain pops one console byte
//   cons_v_o       console FIFO non-empty; cons_data_o is its head
//   halt_q_o       test finished; pass_q_o finished with tohost == 1
//   tohost_q_o     last TOHOST value
//   misalign_q_o   sticky misaligned-access flag
//   drop_cnt_q_o   saturating count of dropped console bytes
module dmem_resp
  import riscv_pkg::*;
#(
  parameter int MEM_DEPTH  = 1024,
  parameter int CONS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  dmem_resp_if.slave      bus,
  input  logic            cons_rd_i,
  output logic            cons_v_o,
  output logic [7:0]      cons_data_o,
  output logic            halt_q_o,
  output logic            pass_q_o,
  output logic [XLEN-1:0] tohost_q_o,
  output logic            misalign_q_o,
  output logic [7:0]      drop_cnt_q_o
);
  localparam int AW = $clog2(MEM_DEPTH) + 2;

  logic [XLEN-1:0] mem_q [MEM_DEPTH];

  halt_st_e        state_q, state_d;
  logic            pass_q, pass_d;
  logic [XLEN-1:0] tohost_q, tohost_d;
  logic            misalign_q, misalign_d;
  logic [7:0]      drop_q, drop_d;

  logic [XLEN-1:0] adr;
  logic [2:0]      sz;
  logic            is_b, is_h, is_w;
  logic            misalign, acc_ok, wr_ok;
  logic            ram_hit, cons_hit, toh_hit;
  logic [AW-3:0]   idx;
  logic [XLEN-1:0] rd_word, rd_shift, wdata;
  logic [NUM_LANES-1:0] be;
  logic            ram_we, cons_push, cons_full, cons_empty, cons_drop, toh_wr;

  assign adr  = bus.adr_i;
  assign sz   = bus.access_size_i;
  assign is_b = (sz == ACC_BYTE);
  assign is_h = (sz == ACC_HALF);
  assign is_w = (sz == ACC_WORD);

  assign misalign = bus.adr_v_i & ((is_h & adr[0]) | (is_w & (|adr[1:0])));
  assign acc_ok   = bus.adr_v_i & ~misalign;

  assign ram_hit  = (adr[XLEN-1:AW] == '0);
  assign cons_hit = (adr == CONS_ADR);
  assign toh_hit  = (adr == TOHOST_ADR);
  assign idx      = adr[AW-1:2];

  // Stores are dead once halted, and a store in a reset cycle is discarded
  // (RAM has no reset, so it must be gated here).
  assign wr_ok = acc_ok & bus.is_store_i & (state_q == ST_RUN) & reset_n;

  // ---------------- load path (combinational) ----------------
  assign rd_word  = mem_q[idx];
  assign rd_shift = rd_word >> {adr[1:0], 3'b000};

  always_comb begin
    bus.load_data_o = '0;
    if (acc_ok) begin
      if (ram_hit) begin
        if (is_b)      bus.load_data_o = {24'b0, rd_shift[7:0]};
        else if (is_h) bus.load_data_o = {16'b0, rd_shift[15:0]};
        else if (is_w) bus.load_data_o = rd_word;
      end else if (cons_hit) begin
        bus.load_data_o = {30'b0, cons_full, ~cons_empty};
      end else if (toh_hit) begin
        bus.load_data_o = tohost_q;
      end
    end
  end

  // ---------------- RAM store path ----------------
  assign be     = lane_en(sz, adr[1:0]);
  assign ram_we = wr_ok & ram_hit;

  // Replicate the store data across lanes; byte enables pick the target.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_wlane
    assign wdata[8*g +: 8] = is_b ? bus.store_data_i[7:0] :
                             is_h ? bus.store_data_i[8*(g%2) +: 8] :
                                    bus.store_data_i[8*g +: 8];
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int l = 0; l < NUM_LANES; l++)
        if (be[l]) mem_q[idx][8*l +: 8] <= wdata[8*l +: 8];
    end
  end

  // ---------------- console ----------------
  assign cons_push = wr_ok & cons_hit & (is_b | is_h | is_w);
  assign cons_drop = cons_push & cons_full & ~cons_rd_i;

  cons_fifo #(.DEPTH(CONS_DEPTH), .WIDTH(8)) u_cons (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (cons_push),
    .din_i   (bus.store_data_i[7:0]),
    .pop_i   (cons_rd_i),
    .dout_o  (cons_data_o),
    .empty_o (cons_empty),
    .full_o  (cons_full)
  );

  assign cons_v_o = ~cons_empty;

  // ---------------- halt FSM + status ----------------
  assign toh_wr = wr_ok & toh_hit & is_w;

  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    tohost_d   = tohost_q;
    misalign_d = misalign_q | misalign;
    drop_d     = drop_q;
    if (cons_drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    case (state_q)
      ST_RUN: begin
        if (toh_wr) begin
          tohost_d = bus.store_data_i;
          if (bus.store_data_i != '0) begin
            state_d = ST_DONE;
            pass_d  = (bus.store_data_i == 32'd1);
          end
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      pass_q     <= 1'b0;
      tohost_q   <= '0;
      misalign_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      pass_q     <= pass_d;
      tohost_q   <= tohost_d;
      misalign_q <= misalign_d;
      drop_q     <= drop_d;
    end
  end

  assign halt_q_o     = (state_q == ST_DONE);
  assign pass_q_o     = pass_q;
  assign tohost_q_o   = tohost_q;
  assign misalign_q_o = misalign_q;
  assign drop_cnt_q_o = drop_q;
endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cons_rd = 1'b0;
  logic        cons_v, halt, pass, misal;
  logic [7:0]  cons_data, drop;
  logic [31:0] tohost;
  int          n_chk = 0;
  int          n_pass = 0;

  dmem_resp_if bus();

  dmem_resp #(.MEM_DEPTH(1024), .CONS_DEPTH(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus.slave),
    .cons_rd_i    (cons_rd),
    .cons_v_o     (cons_v),
    .cons_data_o  (cons_data),
    .halt_q_o     (halt),
    .pass_q_o     (pass),
    .tohost_q_o   (tohost),
    .misalign_q_o (misal),
    .drop_cnt_q_o (drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic idle();
    bus.adr_v_i = 1'b0; bus.is_store_i = 1'b0;
    bus.adr_i = '0; bus.store_data_i = '0; bus.access_size_i = ACC_WORD;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    bus.adr_v_i = 1'b1; bus.is_store_i = 1'b1;
    bus.adr_i = a; bus.store_data_i = d; bus.access_size_i = sz;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic ldchk(input string tag, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] exp);
    bus.adr_v_i = 1'b1; bus.is_store_i = 1'b0;
    bus.adr_i = a; bus.access_size_i = sz;
    #1;
    chk(tag, bus.load_data_o, exp);
    idle();
  endtask

  task automatic pop1();
    cons_rd = 1'b1;
    @(posedge clk); #1;
    cons_rd = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_halt"}, {31'b0, halt}, 32'd0);
    chk({tag, "_pass"}, {31'b0, pass}, 32'd0);
    chk({tag, "_tohost"}, tohost, 32'd0);
    chk({tag, "_misal"}, {31'b0, misal}, 32'd0);
    chk({tag, "_drop"}, {24'b0, drop}, 32'd0);
    chk({tag, "_consv"}, {31'b0, cons_v}, 32'd0);
  endtask

  initial begin
    idle();
    // asynchronous reset, checked before any clock edge
    #1 reset_n = 1'b0;
    #1 chk_reset_vals("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Test 1: lane writes and lane reads
    st(32'h10, 32'hDEADBEEF, ACC_WORD);
    st(32'h11, 32'h00000055, ACC_BYTE);
    ldchk("t1_word", 32'h10, ACC_WORD, 32'hDEAD55EF);
    ldchk("t1_half", 32'h12, ACC_HALF, 32'h0000DEAD);
    ldchk("t1_byte1", 32'h11, ACC_BYTE, 32'h00000055);
    ldchk("t1_byte3", 32'h13, ACC_BYTE, 32'h000000DE);
    st(32'h14, 32'hA5A5_1234, ACC_HALF);
    st(32'h16, 32'h0000_BEEF, ACC_HALF);
    ldchk("t1_halfst", 32'h14, ACC_WORD, 32'hBEEF1234);
    st(32'hFFC, 32'h0BADF00D, ACC_WORD);
    ldchk("ram_top", 32'hFFC, ACC_WORD, 32'h0BADF00D);
    ldchk("unmapped", 32'h1000, ACC_WORD, 32'h0);
    bus.adr_i = 32'h10; bus.access_size_i = ACC_WORD; #1;
    chk("novalid_ld", bus.load_data_o, 32'h0);
    idle();

    // Test 2: misaligned accesses
    st(32'h20, 32'h11223344, ACC_WORD);
    chk("t2_misal0", {31'b0, misal}, 32'd0);
    st(32'h21, 32'h0000AAAA, ACC_HALF);
    chk("t2_misal1", {31'b0, misal}, 32'd1);
    ldchk("t2_ramkeep", 32'h20, ACC_WORD, 32'h11223344);
    ldchk("t2_misld", 32'h22, ACC_WORD, 32'h0);
    chk("t2_sticky", {31'b0, misal}, 32'd1);

    // Test 3: overflow the console, then drain in order
    for (int i = 0; i < 10; i++) st(CONS_ADR, 32'hA0 + i, ACC_BYTE);
    chk("t3_drop", {24'b0, drop}, 32'd2);
    ldchk("t3_status", CONS_ADR, ACC_WORD, 32'h3);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_byte%0d", i), {24'b0, cons_data}, 32'hA0 + i);
      pop1();
    end
    chk("t3_empty", {31'b0, cons_v}, 32'd0);
    ldchk("t3_status0", CONS_ADR, ACC_WORD, 32'h0);

    // Test 4: push and pop together on a full FIFO
    for (int i = 0; i < 8; i++) st(CONS_ADR, 32'hB0 + i, ACC_BYTE);
    cons_rd = 1'b1;
    st(CONS_ADR, 32'hC0, ACC_BYTE);
    cons_rd = 1'b0;
    chk("t4_drop", {24'b0, drop}, 32'd2);
    ldchk("t4_full", CONS_ADR, ACC_WORD, 32'h3);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_byte%0d", i), {24'b0, cons_data}, (i < 7) ? 32'hB1 + i : 32'hC0);
      pop1();
    end
    chk("t4_empty", {31'b0, cons_v}, 32'd0);
    // pop on empty with simultaneous push: push only
    cons_rd = 1'b1;
    st(CONS_ADR, 32'h77, ACC_WORD);
    cons_rd = 1'b0;
    chk("t4_pushonly_v", {31'b0, cons_v}, 32'd1);
    chk("t4_pushonly_d", {24'b0, cons_data}, 32'h77);
    pop1();
    chk("t4_popempty", {31'b0, cons_v}, 32'd0);

    // Test 5: TOHOST / halt
    st(32'h40, 32'hCAFEF00D, ACC_WORD);
    st(TOHOST_ADR, 32'h0, ACC_WORD);
    chk("t5_zero_run", {31'b0, halt}, 32'd0);
    st(TOHOST_ADR, 32'h1, ACC_HALF);
    chk("t5_half_ign", {31'b0, halt}, 32'd0);
    st(TOHOST_ADR, 32'h1, ACC_WORD);
    chk("t5_halt", {31'b0, halt}, 32'd1);
    chk("t5_pass", {31'b0, pass}, 32'd1);
    chk("t5_tohost", tohost, 32'd1);
    st(32'h40, 32'h12345678, ACC_WORD);
    ldchk("t5_ramign", 32'h40, ACC_WORD, 32'hCAFEF00D);
    st(CONS_ADR, 32'h99, ACC_BYTE);
    chk("t5_consign", {31'b0, cons_v}, 32'd0);
    st(TOHOST_ADR, 32'h5, ACC_WORD);
    ldchk("t5_tohostld", TOHOST_ADR, ACC_WORD, 32'h1);
    chk("t5_drop_keep", {24'b0, drop}, 32'd2);
    // reset across a clock edge with a store pending: store is discarded
    bus.adr_v_i = 1'b1; bus.is_store_i = 1'b1; bus.adr_i = 32'h40;
    bus.store_data_i = 32'h99; bus.access_size_i = ACC_WORD;
    reset_n = 1'b0;
    @(posedge clk); #1;
    idle();
    reset_n = 1'b1;
    chk("t5_rst_halt", {31'b0, halt}, 32'd0);
    chk("t5_rst_drop", {24'b0, drop}, 32'd0);
    ldchk("t5_rst_store", 32'h40, ACC_WORD, 32'hCAFEF00D);
    // fresh run ending with a failing code
    for (int i = 0; i < 9; i++) st(CONS_ADR, i, ACC_BYTE);
    chk("t5_drop1", {24'b0, drop}, 32'd1);
    st(32'h21, 32'h0, ACC_WORD);
    st(TOHOST_ADR, 32'h3, ACC_WORD);
    chk("t5_halt3", {31'b0, halt}, 32'd1);
    chk("t5_pass3", {31'b0, pass}, 32'd0);
    chk("t5_tohost3", tohost, 32'd3);
    ldchk("t5_ld_done", CONS_ADR, ACC_WORD, 32'h3);

    // Test 6: asynchronous reset mid-cycle, no clock edge
    #3 reset_n = 1'b0;
    #1 chk_reset_vals("t6");
    #10 reset_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
